seg7_page_ctrl: RTL and testbench
=================================

// Module: seg7_page_ctrl
// PURPOSE
//  Display scheduler for the six DE10-Lite 7-seg digits (HEX5..HEX0). Latches a 32-bit
//  datapath word (PC, register, ALU result) via REQ/ACK and pages it across the digits.
//  Two pages are shown: LO = VALUE[23:0], HI = VALUE[31:24]. Pages change automatically
//  after a dwell time or on a push-button press. Drives six per-digit decoder slices
//  (nibble, enable, dot); decoding to segments happens downstream.
// PARAMETERS
//  PRESC_DIV   50_000_000  CLK cycles per tick (>=2); 1 s at 50 MHz
//  PAGE_TICKS  3           ticks per page in auto mode (>=1)
//  BLINK_TICKS 1           ticks per blink half-period (used only with SEG7_BLINK_EN)
// PORTS
//  CLK     in   1   system clock
//  RST     in   1   asynchronous active-high reset
//  REQ     in   1   load request (level); VALUE is valid while REQ=1
//  VALUE   in   32  word to display
//  ACK     out  1   one-cycle pulse: VALUE latched
//  AUTO    in   1   1 = auto page toggle enabled
//  LZB     in   1   1 = leading-zero blanking within the current page
//  KEY_N   in   1   page button; active-low, asynchronous to CLK
//  PAGE    out  1   current page: 0 = LO, 1 = HI
//  DIG     out  24  nibble per digit; DIG[4k+3:4k] feeds HEXk
//  EN      out  6   per-digit enable (1 = lit)
//  DOT     out  6   per-digit decimal point (1 = lit)
//  BLINK   in   1   only with SEG7_BLINK_EN: 1 = blink the whole display
// BEHAVIOUR
//  Reset: PAGE=0, ACK=0, DIG=0, EN=0, DOT=0; value reg, prescaler, dwell and blink counters = 0.
//  Load: when REQ=1 and ACK=0, latch VALUE and set ACK=1 for exactly one cycle.
//   - If REQ is held high, VALUE re-latches every second cycle.
//   - A load does not change PAGE, the prescaler or the dwell counter.
//  Tick: prescaler counts 0..PRESC_DIV-1; tick=1 in the cycle it wraps to 0.
//  FSM states LO and HI. Toggle when either of these is true:
//   (a) AUTO=1, tick=1 and dwell==PAGE_TICKS-1;
//   (b) a button press, i.e. a falling edge of KEY_N after a 2-FF sync plus edge register.
//   Every toggle clears the prescaler and dwell to 0. Otherwise dwell increments on tick
//   while AUTO=1. AUTO=0 holds dwell at 0.
//   If (a) and (b) occur in the same cycle, the page toggles exactly once.
//  Display map. All outputs are registered: 1-cycle latency from page/value change to DIG/EN/DOT.
//   LO: DIG = val[23:0]; EN = 6'b111111; DOT = 0.
//   HI: DIG = {16'h0, val[31:24]}; EN = 6'b000011; DOT = 6'b100000 (page marker on HEX5, EN[5]=0).
//   LZB=1: within the enabled digits, clear EN for every digit above the most-significant
//   nonzero nibble. The lowest digit (HEX0) always stays enabled.
//   Examples: LO with val[23:0]=0 -> EN=000001; HI with val[31:24]=8'h05 -> EN=000001.
//   A DOT-only digit is still driven: DOT is independent of EN.
//  The KEY_N synchronizer is reset to 1 (released), so no press is seen immediately after reset.
// CONFIGURATION
//  SEG7_BLINK_EN defined:
//   - BLINK port exists. A blink counter counts ticks and toggles a phase bit every BLINK_TICKS.
//   - BLINK=1 and phase=1: EN=0 and DOT=0 on all digits.
//   - BLINK=0: phase is held at 0 and the display is unaffected.
//  SEG7_BLINK_EN undefined: no BLINK port, no blink counter, display never blanks.
// STRUCTURE
//  Package seg7_pkg:
//   - page enum {PG_LO=1'b0, PG_HI=1'b1};
//   - constants NDIG=6, EN_ALL=6'h3F, EN_HI=6'h03, DOT_HI=6'h20.
//  Sub-module seg7_tick_gen (PRESC_DIV): prescaler with sync clear input and one-cycle tick
//  output; shared with the blink path.
//  Top level holds the FSM, dwell counter, REQ/ACK logic, key sync and the LZB mask.
// TESTING
//  Bench: PRESC_DIV=4, PAGE_TICKS=3, BLINK_TICKS=1.
//  1. Reset, then REQ with VALUE=32'hA1B2C3D4 -> ACK pulses 1 cycle; next cycle DIG=24'hB2C3D4,
//     EN=3F, PAGE=0.
//  2. AUTO=1 -> PAGE toggles every 12 cycles; on HI, DIG=24'h0000A1, EN=03, DOT=20.
//  3. LZB=1, VALUE=32'h00000030 -> LO EN=000011; HI EN=000001 with DIG=0.
//  4. KEY_N low pulse 3 cycles long -> exactly one toggle 3 cycles after the falling edge; dwell
//     restarts. A press coincident with the auto toggle -> single toggle.
//  5. REQ held 6 cycles -> ACK=1,0,1,0,1,0; assert RST mid-page -> all outputs 0 immediately.
//  6. SEG7_BLINK_EN defined, BLINK=1 -> EN toggles 3F/00 every 4 cycles; BLINK=0 -> steady.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment page controller.
package seg7_pkg;

    typedef enum logic {PG_LO = 1'b0, PG_HI = 1'b1} page_t;

    localparam int         NDIG   = 6;
    localparam logic [5:0] EN_ALL = 6'h3F;
    localparam logic [5:0] EN_HI  = 6'h03;
    localparam logic [5:0] DOT_HI = 6'h20;

    // Keep every digit at or below the most-significant nonzero nibble; HEX0 always stays lit.
    function automatic logic [NDIG-1:0] lzb_mask(input logic [4*NDIG-1:0] d);
        logic [NDIG-1:0] m;
        logic            seen;
        seen = 1'b0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            seen = seen | (|d[4*i +: 4]);
            m[i] = seen;
        end
        m[0] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/seg7_tick_gen.sv
// Prescaler: counts 0..PRESC_DIV-1 and pulses tick in the wrap cycle.
// A synchronous clear restarts the count from 0.
module seg7_tick_gen #(
    parameter int PRESC_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int CW = $clog2(PRESC_DIV);

    logic [CW-1:0] cnt;

    // tick must not depend on clr: clr is itself derived from tick upstream
    assign tick = (cnt == CW'(PRESC_DIV - 1));

    // Free-running count with clear and wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              cnt <= '0;
        else if (clr || tick) cnt <= '0;
        else                  cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/seg7_page_ctrl.sv
// Display scheduler for six 7-seg digits: latches a 32-bit word via REQ/ACK and
// pages it as LO = VALUE[23:0] / HI = VALUE[31:24], by dwell timer or button.
// Optional feature macro: SEG7_BLINK_EN (adds BLINK port and whole-display blink).
module seg7_page_ctrl
    import seg7_pkg::*;
#(
    parameter int PRESC_DIV  = 50_000_000,
    parameter int PAGE_TICKS = 3
`ifdef SEG7_BLINK_EN
    , parameter int BLINK_TICKS = 1
`endif
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ,
    input  logic [31:0] VALUE,
    output logic        ACK,
    input  logic        AUTO,
    input  logic        LZB,
    input  logic        KEY_N,
    output logic        PAGE,
    output logic [23:0] DIG,
    output logic [5:0]  EN,
    output logic [5:0]  DOT
`ifdef SEG7_BLINK_EN
    , input logic       BLINK
`endif
);
    localparam int DW = $clog2(PAGE_TICKS + 1);

    page_t          page_q;
    logic [31:0]    val_q;
    logic [DW-1:0]  dwell;
    logic           tick;
    logic           key_s1, key_s2, key_q;
    logic           press;
    logic           auto_hit;
    logic           toggle;

    assign press    = key_q & ~key_s2;
    assign auto_hit = AUTO && tick && (dwell == DW'(PAGE_TICKS - 1));
    assign toggle   = auto_hit | press;   // simultaneous causes collapse to one toggle
    assign PAGE     = page_q;

    seg7_tick_gen #(.PRESC_DIV(PRESC_DIV)) u_tick (
        .clk  (CLK),
        .rst  (RST),
        .clr  (toggle),
        .tick (tick)
    );

    // REQ/ACK handshake: latch on REQ while no ACK is outstanding
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            val_q <= '0;
            ACK   <= 1'b0;
        end else if (REQ && !ACK) begin
            val_q <= VALUE;
            ACK   <= 1'b1;
        end else begin
            ACK   <= 1'b0;
        end
    end

    // Button synchronizer plus edge register, idle high so reset is not a press
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            key_s1 <= 1'b1;
            key_s2 <= 1'b1;
            key_q  <= 1'b1;
        end else begin
            key_s1 <= KEY_N;
            key_s2 <= key_s1;
            key_q  <= key_s2;
        end
    end

    // Page FSM and dwell counter
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            page_q <= PG_LO;
            dwell  <= '0;
        end else if (toggle) begin
            page_q <= (page_q == PG_LO) ? PG_HI : PG_LO;
            dwell  <= '0;
        end else if (!AUTO) begin
            dwell  <= '0;
        end else if (tick) begin
            dwell  <= dwell + 1'b1;
        end
    end

`ifdef SEG7_BLINK_EN
    localparam int BW = $clog2(BLINK_TICKS + 1);
    logic [BW-1:0] blink_cnt;
    logic          phase;

    // Blink phase flips every BLINK_TICKS ticks; parked at 0 while BLINK is low
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (!BLINK) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (tick) begin
            if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end
`endif

    logic [23:0] page_data;
    logic [5:0]  en_base, dot_base, en_nxt, dot_nxt;
    logic        blank;

    // Next display image from page, latched value and blanking controls
    always_comb begin
        page_data = (page_q == PG_HI) ? {16'h0, val_q[31:24]} : val_q[23:0];
        en_base   = (page_q == PG_HI) ? EN_HI  : EN_ALL;
        dot_base  = (page_q == PG_HI) ? DOT_HI : 6'h00;
        en_nxt    = LZB ? (en_base & lzb_mask(page_data)) : en_base;
        dot_nxt   = dot_base;
`ifdef SEG7_BLINK_EN
        blank     = BLINK & phase;
`else
        blank     = 1'b0;
`endif
        if (blank) begin
            en_nxt  = 6'h00;
            dot_nxt = 6'h00;
        end
    end

    // Registered digit outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            DIG <= '0;
            EN  <= '0;
            DOT <= '0;
        end else begin
            DIG <= page_data;
            EN  <= en_nxt;
            DOT <= dot_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_page_ctrl.sv
// Self-checking bench for seg7_page_ctrl (PRESC_DIV=4, PAGE_TICKS=3, BLINK_TICKS=1).
module tb_seg7_page_ctrl;

    logic        CLK = 1'b0;
    logic        RST, REQ, AUTO, LZB, KEY_N, ACK, PAGE;
    logic [31:0] VALUE;
    logic [23:0] DIG;
    logic [5:0]  EN, DOT;
`ifdef SEG7_BLINK_EN
    logic        BLINK;
`endif

    int n_pass = 0;
    int n_total = 0;

    always #5 CLK = ~CLK;

    seg7_page_ctrl #(
        .PRESC_DIV(4), .PAGE_TICKS(3)
`ifdef SEG7_BLINK_EN
        , .BLINK_TICKS(1)
`endif
    ) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .VALUE(VALUE), .ACK(ACK),
        .AUTO(AUTO), .LZB(LZB), .KEY_N(KEY_N), .PAGE(PAGE),
        .DIG(DIG), .EN(EN), .DOT(DOT)
`ifdef SEG7_BLINK_EN
        , .BLINK(BLINK)
`endif
    );

    typedef struct {
        logic [31:0] val;
        logic        lzb;
        logic        hi;
        logic [23:0] dig;
        logic [5:0]  en;
        logic [5:0]  dot;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic load(input logic [31:0] v);
        @(negedge CLK); REQ = 1'b1; VALUE = v;
        @(negedge CLK); REQ = 1'b0;
        @(negedge CLK);
    endtask

    task automatic press();
        @(negedge CLK); KEY_N = 1'b0;
        repeat (3) @(negedge CLK);
        KEY_N = 1'b1;
        repeat (3) @(negedge CLK);
    endtask

    task automatic wait_toggle(output int n, output bit ok);
        logic p;
        p  = PAGE;
        n  = 0;
        ok = 1'b0;
        while (n < 60 && !ok) begin
            @(negedge CLK);
            n++;
            if (PAGE !== p) ok = 1'b1;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_page"}, 32'(PAGE), 32'h0);
        chk({tag, "_ack"},  32'(ACK),  32'h0);
        chk({tag, "_dig"},  32'(DIG),  32'h0);
        chk({tag, "_en"},   32'(EN),   32'h0);
        chk({tag, "_dot"},  32'(DOT),  32'h0);
    endtask

    initial begin
        int  n;
        bit  ok;
        logic cur_hi;

        vecs[0] = '{32'hA1B2C3D4, 1'b0, 1'b0, 24'hB2C3D4, 6'h3F, 6'h00};
        vecs[1] = '{32'hA1B2C3D4, 1'b0, 1'b1, 24'h0000A1, 6'h03, 6'h20};
        vecs[2] = '{32'h00000030, 1'b1, 1'b0, 24'h000030, 6'h03, 6'h00};
        vecs[3] = '{32'h00000030, 1'b1, 1'b1, 24'h000000, 6'h01, 6'h20};
        vecs[4] = '{32'h05000000, 1'b1, 1'b1, 24'h000005, 6'h01, 6'h20};
        vecs[5] = '{32'h00000000, 1'b1, 1'b0, 24'h000000, 6'h01, 6'h00};
        vecs[6] = '{32'h12345678, 1'b1, 1'b0, 24'h345678, 6'h3F, 6'h00};
        vecs[7] = '{32'h00012300, 1'b1, 1'b0, 24'h012300, 6'h1F, 6'h00};
        vecs[8] = '{32'hFF000000, 1'b0, 1'b0, 24'h000000, 6'h3F, 6'h00};
        vecs[9] = '{32'hFF000000, 1'b1, 1'b1, 24'h0000FF, 6'h03, 6'h20};

        RST = 1'b1; REQ = 1'b0; VALUE = '0; AUTO = 1'b0; LZB = 1'b0; KEY_N = 1'b1;
`ifdef SEG7_BLINK_EN
        BLINK = 1'b0;
`endif
        repeat (2) @(negedge CLK);
        chk_zero("reset");
        RST = 1'b0;

        // single load: one-cycle ACK, display one cycle later
        @(negedge CLK); REQ = 1'b1; VALUE = 32'hA1B2C3D4;
        @(negedge CLK); chk("ack_pulse", 32'(ACK), 32'h1); REQ = 1'b0;
        @(negedge CLK);
        chk("ack_drop", 32'(ACK), 32'h0);
        chk("load_dig", 32'(DIG), 32'h00B2C3D4);
        chk("load_en",  32'(EN),  32'h3F);
        chk("load_page", 32'(PAGE), 32'h0);

        // table: value, LZB and page selection with AUTO off
        cur_hi = 1'b0;
        for (int i = 0; i < 10; i++) begin
            LZB = vecs[i].lzb;
            load(vecs[i].val);
            if (vecs[i].hi != cur_hi) begin
                press();
                cur_hi = vecs[i].hi;
            end else begin
                @(negedge CLK);
            end
            chk($sformatf("v%0d_page", i), 32'(PAGE), 32'(vecs[i].hi));
            chk($sformatf("v%0d_dig", i),  32'(DIG),  32'(vecs[i].dig));
            chk($sformatf("v%0d_en", i),   32'(EN),   32'(vecs[i].en));
            chk($sformatf("v%0d_dot", i),  32'(DOT),  32'(vecs[i].dot));
        end
        if (cur_hi) press();
        LZB = 1'b0;

        // REQ held: ACK alternates and value re-latches
        @(negedge CLK); REQ = 1'b1; VALUE = 32'hA1B2C3D4;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            chk($sformatf("held_ack%0d", k), 32'(ACK), (k % 2 == 0) ? 32'h1 : 32'h0);
        end
        REQ = 1'b0;

        // auto mode, aligned by a press that toggles to HI and restarts dwell
        @(negedge CLK); AUTO = 1'b1; KEY_N = 1'b0;
        repeat (3) @(negedge CLK);
        KEY_N = 1'b1;
        chk("auto_start_hi", 32'(PAGE), 32'h1);
        @(negedge CLK);
        chk("hi_dig", 32'(DIG), 32'h000000A1);
        chk("hi_en",  32'(EN),  32'h03);
        chk("hi_dot", 32'(DOT), 32'h20);
        wait_toggle(n, ok);
        chk("auto_first_int", 32'(n), 32'd11);
        wait_toggle(n, ok);
        chk("auto_period", 32'(n), 32'd12);
        chk("auto_back_hi", 32'(PAGE), 32'h1);

        // press 3 cycles after an auto toggle: toggles at +6, dwell restarts
        repeat (3) @(negedge CLK);
        KEY_N = 1'b0;
        repeat (3) @(negedge CLK);
        KEY_N = 1'b1;
        chk("press_toggle", 32'(PAGE), 32'h0);
        wait_toggle(n, ok);
        chk("dwell_restart", 32'(n), 32'd12);
        chk("restart_hi", 32'(PAGE), 32'h1);

        // press landing on the same edge as the auto toggle: single toggle
        repeat (9) @(negedge CLK);
        KEY_N = 1'b0;
        repeat (3) @(negedge CLK);
        KEY_N = 1'b1;
        chk("coincide_once", 32'(PAGE), 32'h0);
        wait_toggle(n, ok);
        chk("coincide_next", 32'(n), 32'd12);

        // asynchronous reset in the middle of a HI page
        repeat (3) @(negedge CLK);
        #2 RST = 1'b1;
        #1 chk_zero("midrst");
        @(negedge CLK); RST = 1'b0; AUTO = 1'b0;
        repeat (2) @(negedge CLK);

`ifdef SEG7_BLINK_EN
        BLINK = 1'b1;
        begin
            logic [5:0] e0;
            int m;
            e0 = EN; m = 0;
            while (EN === e0 && m < 20) begin @(negedge CLK); m++; end
            chk("blink_seen", 32'(m < 20), 32'h1);
            for (int j = 0; j < 3; j++) begin
                e0 = EN; m = 0;
                while (EN === e0 && m < 20) begin @(negedge CLK); m++; end
                chk($sformatf("blink_int%0d", j), 32'(m), 32'd4);
                chk($sformatf("blink_en%0d", j), 32'(EN), (e0 == 6'h3F) ? 32'h00 : 32'h3F);
            end
        end
        BLINK = 1'b0;
        repeat (2) @(negedge CLK);
        for (int j = 0; j < 8; j++) begin
            @(negedge CLK);
            chk($sformatf("steady%0d", j), 32'(EN), 32'h3F);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
